ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised execute stage for the in-order pipeline, sitting between decode (ID) and memory (MEM).
- Holds one instruction under a valid/allow_in handshake.
- Resolves all six conditional branches in EX, with a single-cycle redirect and a wrong-path squash.
- Generates byte-lane store enables for byte, half, word and double stores, and flags misalignment.
- Runs signed and unsigned division and remainder on an iterative radix-2 divider, which stalls the stage for a fixed number of cycles.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
REG_AW, 5, destination register address width.
LANES, XLEN/8, store byte lanes; this is derived and must not be overridden.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
ex_allow_in  out  1  EX can accept an instruction this cycle
id_pc  in  XLEN  instruction PC
id_src1  in  XLEN  rj value
id_src2  in  XLEN  rk/rd value (also the store data)
id_imm  in  XLEN  sign-extended immediate
id_src2_is_imm  in  1  second ALU operand is id_imm
id_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 DIV, 8 DIVU, 9 MOD, 10 MODU, 11 LOAD, 12 STORE, 13 BR; 14 and 15 reserved, treated as ADD
id_br_cond  in  3  0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU
id_br_target  in  XLEN  precomputed branch target
id_mem_size  in  2  log2 of access bytes
id_gr_we  in  1  register write enable
id_dest  in  REG_AW  destination register
mem_allow_in  in  1  MEM can accept an instruction
mem_valid  out  1  EX presents an instruction to MEM
mem_pc  out  XLEN  PC, forwarded to MEM
mem_result  out  XLEN  ALU or divider result, or the effective address
mem_gr_we  out  1  register write enable, forwarded
mem_dest  out  REG_AW  destination, forwarded
mem_res_from_mem  out  1  instruction is a LOAD
mem_ale  out  1  misaligned LOAD/STORE
br_taken  out  1  redirect pulse to IF
br_target  out  XLEN  redirect address
data_sram_en  out  1  memory request enable
data_sram_we  out  LANES  byte write enables
data_sram_addr  out  XLEN  access address
data_sram_wdata  out  XLEN  lane-replicated store data

Behaviour:
Handshake
- ex_allow_in = !ex_valid || (ready_go && mem_allow_in).
- Fire = ex_valid && ready_go && mem_allow_in.
- mem_valid = ex_valid && ready_go.
- When id_valid && ex_allow_in, all id_* fields are latched and ex_valid <= 1.
- When ex_allow_in && !id_valid, ex_valid <= 0.

Reset
- ex_valid = 0, divider state = IDLE, and all outputs are 0.
- A reset during a division aborts it; no result is produced.

Arithmetic
- Operand 2 = id_src2_is_imm ? imm : src2.
- Operations are modulo 2^XLEN.
- SLT/SLTU produce 1 or 0, zero-extended.
- LOAD/STORE: the result is src1 + imm.

Branch
- The condition is evaluated on src1 vs src2; signed for LT/GE, unsigned for LTU/GEU.
- br_taken = fire && op==BR && condition true. It is a single-cycle pulse and is never repeated during a stall.
- br_target = the latched target.
- In a cycle with br_taken, ex_valid <= 0 regardless of id_valid. The wrong-path instruction is dropped; ex_allow_in stays 1.
- A BR sets mem_gr_we = 0.

Divider FSM (IDLE, BUSY, DONE)
- IDLE → BUSY when ex_valid and op is DIV/DIVU/MOD/MODU. The operand absolute values are loaded and the counter is set to XLEN.
- BUSY: one restoring step per cycle; the counter decrements; BUSY → DONE when the counter reaches 0.
- DONE: sign fix-up is complete and ready_go = 1. DONE → IDLE on fire.
- ready_go = 0 in IDLE (for a divide op) and in BUSY. ready_go = 1 otherwise.
- Latency: mem_valid rises XLEN+1 cycles after a divide op is latched.
- Signed rules: the quotient truncates toward zero and the remainder takes the sign of the dividend. MIN / -1 gives quotient MIN and remainder 0.
- Divisor 0: quotient = all ones, remainder = dividend, for both signed and unsigned. Latency is unchanged.

Memory
- data_sram_en = ex_valid && (op is LOAD or STORE).
- data_sram_addr = the effective address.
- Offset = addr[log2(LANES)-1:0].
- mem_ale = (offset mod 2^size ≠ 0) or (size==3 with XLEN==32).
- The write mask is 2^size ones shifted left by offset.
- data_sram_we = mask only when fire && op==STORE && !mem_ale; it is 0 otherwise. The write is therefore issued exactly once, even across MEM stalls.
- wdata = the low 2^size bytes of src2, replicated across all lanes.

Test Plan:
- XLEN=32, ADD 5 + 0xFFFFFFFD with mem_allow_in=1 → mem_valid the next cycle, mem_result=2.
- BEQ 7 vs 7 with target 0x1C00_0040, with ID offering another instruction in the same cycle → br_taken for exactly 1 cycle, br_target=0x1C000040, the next-cycle ex_valid=0, and no mem_valid for the dropped instruction.
- DIV -7 / 2 → mem_valid exactly 33 cycles after the latch, result -3; MOD gives -1; DIVU 10/0 gives 0xFFFFFFFF; MODU 10/0 gives 10.
- STORE byte, addr 0x1003, src2 0x000000AB → data_sram_we=4'b1000, wdata=0xABABABAB. STORE half at 0x1001 → mem_ale=1, we=0.
- Store with mem_allow_in held 0 for 3 cycles, then 1 → data_sram_we non-zero in exactly one cycle.
- Reset asserted in the middle of a divide at cycle 10 → ex_valid=0 and FSM IDLE the next cycle; a subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage of the in-order pipeline (between ID and MEM).
// Holds one instruction under a valid/allow_in handshake, resolves branches
// with a single-cycle redirect, builds byte-lane store enables, and runs
// DIV/DIVU/MOD/MODU on an iterative radix-2 restoring divider.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_*  / ex_allow_in        instruction from ID and the accept handshake
//   mem_* / mem_allow_in       instruction to MEM and its backpressure
//   br_taken, br_target        redirect pulse and address to IF
//   data_sram_*                data memory request (enable, lane mask, addr, wdata)
module ex_stage_mc #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    localparam int unsigned LANES = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              ex_allow_in,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_src1,
    input  logic [XLEN-1:0]   id_src2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_src2_is_imm,
    input  logic [3:0]        id_op,
    input  logic [2:0]        id_br_cond,
    input  logic [XLEN-1:0]   id_br_target,
    input  logic [1:0]        id_mem_size,
    input  logic              id_gr_we,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              mem_allow_in,
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_pc,
    output logic [XLEN-1:0]   mem_result,
    output logic              mem_gr_we,
    output logic [REG_AW-1:0] mem_dest,
    output logic              mem_res_from_mem,
    output logic              mem_ale,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic              data_sram_en,
    output logic [LANES-1:0]  data_sram_we,
    output logic [XLEN-1:0]   data_sram_addr,
    output logic [XLEN-1:0]   data_sram_wdata
);

    localparam int unsigned OFFW = $clog2(LANES);
    localparam int unsigned CNTW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MOD   = 4'd9;
    localparam logic [3:0] OP_MODU  = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;
    localparam logic [3:0] OP_BR    = 4'd13;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    // Latched instruction
    logic              ex_valid_q;
    logic [XLEN-1:0]   pc_q, src1_q, src2_q, imm_q, target_q;
    logic              src2_is_imm_q, gr_we_q;
    logic [3:0]        op_q;
    logic [2:0]        cond_q;
    logic [1:0]        size_q;
    logic [REG_AW-1:0] dest_q;

    // Divider state
    div_state_e        div_state_q, div_state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic [XLEN-1:0]   op2, eff_addr, alu_res, quo_fix, rem_fix;
    logic [XLEN:0]     rem_sh;
    logic              is_div, is_mem, div_signed, a_neg, b_neg;
    logic              ready_go, fire, cond_true, align_bad;
    logic [31:0]       nbytes, off;
    logic [LANES-1:0]  mask;
    logic [XLEN-1:0]   wdata_rep;

    assign op2        = src2_is_imm_q ? imm_q : src2_q;
    assign eff_addr   = src1_q + imm_q;
    assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_MOD) || (op_q == OP_MODU);
    assign is_mem     = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign div_signed = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign a_neg      = div_signed && src1_q[XLEN-1];
    assign b_neg      = div_signed && op2[XLEN-1];

    // Handshake: a divide holds the stage until its result is in DONE
    assign ready_go    = !(is_div && (div_state_q != DIV_DONE));
    assign mem_valid   = ex_valid_q && ready_go;
    assign fire        = mem_valid && mem_allow_in;
    assign ex_allow_in = !ex_valid_q || (ready_go && mem_allow_in);

    // Branch condition on the raw register operands
    always_comb begin
        cond_true = 1'b0;
        case (cond_q)
            3'd0:    cond_true = (src1_q == src2_q);
            3'd1:    cond_true = (src1_q != src2_q);
            3'd2:    cond_true = ($signed(src1_q) <  $signed(src2_q));
            3'd3:    cond_true = ($signed(src1_q) >= $signed(src2_q));
            3'd4:    cond_true = (src1_q <  src2_q);
            3'd5:    cond_true = (src1_q >= src2_q);
            default: cond_true = 1'b0;
        endcase
    end

    // Redirect only on the firing cycle, so a stall cannot repeat it
    assign br_taken  = fire && (op_q == OP_BR) && cond_true;
    assign br_target = target_q;

    // Pipeline register; a taken branch squashes whatever ID offers
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            pc_q          <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            imm_q         <= '0;
            target_q      <= '0;
            src2_is_imm_q <= 1'b0;
            gr_we_q       <= 1'b0;
            op_q          <= '0;
            cond_q        <= '0;
            size_q        <= '0;
            dest_q        <= '0;
        end else if (ex_allow_in) begin
            ex_valid_q <= id_valid && !br_taken;
            if (id_valid && !br_taken) begin
                pc_q          <= id_pc;
                src1_q        <= id_src1;
                src2_q        <= id_src2;
                imm_q         <= id_imm;
                target_q      <= id_br_target;
                src2_is_imm_q <= id_src2_is_imm;
                gr_we_q       <= id_gr_we;
                op_q          <= id_op;
                cond_q        <= id_br_cond;
                size_q        <= id_mem_size;
                dest_q        <= id_dest;
            end
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state_q <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
        end
    end

    // Divider next state: magnitudes in, one restoring step per BUSY cycle
    assign rem_sh = {rem_q, quo_q[XLEN-1]};

    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (ex_valid_q && is_div) begin
                    div_state_d = DIV_BUSY;
                    cnt_d       = CNTW'(XLEN);
                    rem_d       = '0;
                    quo_d       = a_neg ? -src1_q : src1_q;
                    dvsr_d      = b_neg ? -op2 : op2;
                    neg_quo_d   = a_neg ^ b_neg;
                    neg_rem_d   = a_neg;
                    dz_d        = (op2 == '0);
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q - CNTW'(1);
                if (rem_sh >= {1'b0, dvsr_q}) begin
                    rem_d = XLEN'(rem_sh - {1'b0, dvsr_q});
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CNTW'(1)) begin
                    div_state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (fire) begin
                    div_state_d = DIV_IDLE;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    // Sign fix-up; divide-by-zero returns all ones / the dividend unchanged
    assign quo_fix = dz_q ? '1     : (neg_quo_q ? -quo_q : quo_q);
    assign rem_fix = dz_q ? src1_q : (neg_rem_q ? -rem_q : rem_q);

    // Result mux; reserved ops and BR fall through to ADD
    always_comb begin
        alu_res = src1_q + op2;
        case (op_q)
            OP_SUB:            alu_res = src1_q - op2;
            OP_AND:            alu_res = src1_q & op2;
            OP_OR:             alu_res = src1_q | op2;
            OP_XOR:            alu_res = src1_q ^ op2;
            OP_SLT:            alu_res = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(op2)};
            OP_SLTU:           alu_res = {{(XLEN-1){1'b0}}, src1_q < op2};
            OP_DIV, OP_DIVU:   alu_res = quo_fix;
            OP_MOD, OP_MODU:   alu_res = rem_fix;
            OP_LOAD, OP_STORE: alu_res = eff_addr;
            default:           alu_res = src1_q + op2;
        endcase
    end

    // Lane mask, alignment and store-data replication
    always_comb begin
        nbytes    = 32'd1 << size_q;
        off       = 32'(eff_addr[OFFW-1:0]);
        align_bad = ((off % nbytes) != 32'd0) || ((size_q == 2'd3) && (XLEN == 32));
        mask      = '0;
        wdata_rep = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            mask[i]             = (i >= off) && (i < off + nbytes);
            wdata_rep[8*i +: 8] = src2_q[8*(i % nbytes) +: 8];
        end
    end

    assign mem_pc           = pc_q;
    assign mem_result       = alu_res;
    assign mem_gr_we        = gr_we_q && (op_q != OP_BR);
    assign mem_dest         = dest_q;
    assign mem_res_from_mem = (op_q == OP_LOAD);
    assign mem_ale          = is_mem && align_bad;
    assign data_sram_en     = ex_valid_q && is_mem;
    // Write only on the handshake cycle so a MEM stall never repeats it
    assign data_sram_we     = (fire && (op_q == OP_STORE) && !align_bad) ? mask : '0;
    assign data_sram_addr   = eff_addr;
    assign data_sram_wdata  = wdata_rep;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed and random instructions, expected results
// queued at issue, checked by an independent monitor when MEM takes them.
module tb_ex_stage_mc;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_DIV = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8, OP_MOD = 4'd9, OP_MODU = 4'd10, OP_LOAD = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12, OP_BR = 4'd13;

    typedef struct {
        logic [31:0] pc, src1, src2, imm, target;
        logic        is_imm, gr_we;
        logic [3:0]  op;
        logic [2:0]  cond;
        logic [1:0]  size;
        logic [4:0]  dest;
    } ins_t;

    typedef struct {
        logic [31:0] pc, res, target, wdata;
        bit          chk_res, chk_wdata;
        logic        gr_we, from_mem, ale, br, en;
        logic [4:0]  dest;
        logic [3:0]  we;
        int          accept, lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset, id_valid, ex_allow_in;
    logic [XLEN-1:0]   id_pc, id_src1, id_src2, id_imm, id_br_target;
    logic              id_src2_is_imm, id_gr_we;
    logic [3:0]        id_op;
    logic [2:0]        id_br_cond;
    logic [1:0]        id_mem_size;
    logic [REG_AW-1:0] id_dest;
    logic              mem_allow_in, mem_valid, mem_gr_we, mem_res_from_mem, mem_ale;
    logic [XLEN-1:0]   mem_pc, mem_result, br_target, data_sram_addr, data_sram_wdata;
    logic [REG_AW-1:0] mem_dest;
    logic              br_taken, data_sram_en;
    logic [3:0]        data_sram_we;

    ex_stage_mc #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .ex_allow_in(ex_allow_in),
        .id_pc(id_pc), .id_src1(id_src1), .id_src2(id_src2), .id_imm(id_imm),
        .id_src2_is_imm(id_src2_is_imm), .id_op(id_op), .id_br_cond(id_br_cond),
        .id_br_target(id_br_target), .id_mem_size(id_mem_size), .id_gr_we(id_gr_we),
        .id_dest(id_dest), .mem_allow_in(mem_allow_in), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_result(mem_result), .mem_gr_we(mem_gr_we),
        .mem_dest(mem_dest), .mem_res_from_mem(mem_res_from_mem), .mem_ale(mem_ale),
        .br_taken(br_taken), .br_target(br_target), .data_sram_en(data_sram_en),
        .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors = 0, miscompares = 0;
    exp_t expq[$];
    exp_t mon_e;
    int   first_seen = -1;
    bit   bp_en = 1'b0, force_allow = 1'b1;
    logic [31:0] pc_ctr = 32'h1C00_0000;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: architectural meaning of each op, plain arithmetic
    function automatic exp_t model(input ins_t i);
        exp_t e;
        logic [31:0] op2, addr;
        logic signed [31:0] sa, sb;
        int unsigned nb, ofs;
        bit ct;
        e = '{default: '0};
        op2 = i.is_imm ? i.imm : i.src2;
        sa = i.src1;
        sb = op2;
        e.pc = i.pc; e.dest = i.dest; e.chk_res = 1'b1;
        e.gr_we = i.gr_we && (i.op != OP_BR);
        e.from_mem = (i.op == OP_LOAD);
        case (i.op)
            OP_SUB:  e.res = i.src1 - op2;
            OP_AND:  e.res = i.src1 & op2;
            OP_OR:   e.res = i.src1 | op2;
            OP_XOR:  e.res = i.src1 ^ op2;
            OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (i.src1 < op2) ? 32'd1 : 32'd0;
            OP_DIV:  e.res = (op2 == 0) ? 32'hFFFF_FFFF :
                             (i.src1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            OP_MOD:  e.res = (op2 == 0) ? i.src1 :
                             (i.src1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            OP_DIVU: e.res = (op2 == 0) ? 32'hFFFF_FFFF : i.src1 / op2;
            OP_MODU: e.res = (op2 == 0) ? i.src1 : i.src1 % op2;
            OP_LOAD, OP_STORE: e.res = i.src1 + i.imm;
            OP_BR:   e.chk_res = 1'b0;
            default: e.res = i.src1 + op2;
        endcase
        e.lat = (i.op >= OP_DIV && i.op <= OP_MODU) ? int'(XLEN) + 1 : 0;
        addr = i.src1 + i.imm;
        ofs = addr % 4;
        nb = 1 << i.size;
        e.en  = (i.op == OP_LOAD) || (i.op == OP_STORE);
        e.ale = e.en && (((ofs % nb) != 0) || (i.size == 2'd3));
        if (i.op == OP_STORE && !e.ale) begin
            e.we = 4'(((1 << nb) - 1) << ofs);
            e.chk_wdata = 1'b1;
            case (i.size)
                2'd0:    e.wdata = {4{i.src2[7:0]}};
                2'd1:    e.wdata = {2{i.src2[15:0]}};
                default: e.wdata = i.src2;
            endcase
        end
        case (i.cond)
            3'd0: ct = (i.src1 == i.src2);
            3'd1: ct = (i.src1 != i.src2);
            3'd2: ct = ($signed(i.src1) < $signed(i.src2));
            3'd3: ct = ($signed(i.src1) >= $signed(i.src2));
            3'd4: ct = (i.src1 < i.src2);
            3'd5: ct = (i.src1 >= i.src2);
            default: ct = 1'b0;
        endcase
        e.br = (i.op == OP_BR) && ct;
        e.target = i.target;
        return e;
    endfunction

    function automatic ins_t mk(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] imm, input logic is_imm, input logic [1:0] size);
        ins_t i;
        i.pc = pc_ctr; i.op = op; i.src1 = s1; i.src2 = s2; i.imm = imm; i.is_imm = is_imm;
        i.size = size; i.cond = 3'd0; i.target = 32'h0; i.gr_we = 1'b1; i.dest = 5'd3;
        return i;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.op = 4'($urandom_range(0, 15));
        if (i.op >= OP_DIV && i.op <= OP_MODU && $urandom_range(0, 3) != 0)
            i.op = 4'($urandom_range(0, 6));
        i.pc = pc_ctr; i.src1 = pick_val(); i.src2 = pick_val(); i.imm = pick_val();
        i.is_imm = 1'($urandom_range(0, 1));
        if (i.op == OP_LOAD || i.op == OP_STORE) begin
            i.src1 = 32'h1000 + 32'($urandom_range(0, 63));
            i.imm  = 32'($urandom_range(0, 7));
        end
        if (i.op == OP_BR && $urandom_range(0, 1) == 1) i.src2 = i.src1;
        i.cond = 3'($urandom_range(0, 7));
        i.size = 2'($urandom_range(0, 3));
        i.target = $urandom;
        i.gr_we = 1'($urandom_range(0, 1));
        i.dest = 5'($urandom_range(0, 31));
        return i;
    endfunction

    // Offer one instruction; queue its expectation unless a taken branch drops it
    task automatic issue(input ins_t ins);
        bit done = 1'b0, dropped = 1'b0;
        exp_t e;
        id_pc = ins.pc; id_src1 = ins.src1; id_src2 = ins.src2; id_imm = ins.imm;
        id_src2_is_imm = ins.is_imm; id_op = ins.op; id_br_cond = ins.cond;
        id_br_target = ins.target; id_mem_size = ins.size; id_gr_we = ins.gr_we; id_dest = ins.dest;
        id_valid = 1'b1;
        pc_ctr = pc_ctr + 32'd4;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (ex_allow_in) begin
                done = 1'b1;
                dropped = br_taken;
                if (!dropped) begin
                    e = model(ins);
                    e.accept = cyc + 1;
                    expq.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        id_valid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout: pc %h never accepted, required accept within 200 cycles", ins.pc);
        end
        if (dropped) begin
            @(negedge clk);
            chk("drop_mem_valid", 32'(mem_valid), 32'd0);
            chk("drop_allow_in", 32'(ex_allow_in), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d entries left, required 0", expq.size());
        end
    endtask

    // MEM-side backpressure, changed after the driver so it never races sampling
    initial begin
        mem_allow_in = 1'b1;
        forever begin
            @(posedge clk); #2;
            mem_allow_in = bp_en ? ($urandom_range(0, 9) < 7) : force_allow;
        end
    end

    // Monitor: compares whatever MEM takes against the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            first_seen = -1;
        end else begin
            if (mem_valid && first_seen < 0) first_seen = cyc;
            if (mem_valid && mem_allow_in) begin
                if (expq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_fire: pc %h presented, scoreboard empty", mem_pc);
                end else begin
                    mon_e = expq.pop_front();
                    chk("pc", mem_pc, mon_e.pc);
                    if (mon_e.chk_res) chk("result", mem_result, mon_e.res);
                    chk("gr_we", 32'(mem_gr_we), 32'(mon_e.gr_we));
                    chk("dest", 32'(mem_dest), 32'(mon_e.dest));
                    chk("res_from_mem", 32'(mem_res_from_mem), 32'(mon_e.from_mem));
                    chk("ale", 32'(mem_ale), 32'(mon_e.ale));
                    chk("sram_en", 32'(data_sram_en), 32'(mon_e.en));
                    chk("sram_we", 32'(data_sram_we), 32'(mon_e.we));
                    if (mon_e.chk_wdata) chk("sram_wdata", data_sram_wdata, mon_e.wdata);
                    if (mon_e.en) chk("sram_addr", data_sram_addr, mon_e.res);
                    chk("br_taken", 32'(br_taken), 32'(mon_e.br));
                    if (mon_e.br) chk("br_target", br_target, mon_e.target);
                    chk("latency", 32'(first_seen - mon_e.accept), 32'(mon_e.lat));
                end
                first_seen = -1;
            end else begin
                chk("stray_br_taken", 32'(br_taken), 32'd0);
                chk("stray_sram_we", 32'(data_sram_we), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t ins;
        reset = 1'b1; id_valid = 1'b0;
        id_pc = '0; id_src1 = '0; id_src2 = '0; id_imm = '0; id_src2_is_imm = 1'b0;
        id_op = '0; id_br_cond = '0; id_br_target = '0; id_mem_size = '0;
        id_gr_we = 1'b0; id_dest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_allow_in", 32'(ex_allow_in), 32'd1);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_sram_en", 32'(data_sram_en), 32'd0);
        chk("rst_sram_we", 32'(data_sram_we), 32'd0);
        chk("rst_result", mem_result, 32'd0);
        chk("rst_gr_we", 32'(mem_gr_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        issue(mk(OP_ADD, 32'd5, 32'hFFFF_FFFD, 32'd0, 1'b0, 2'd0));
        ins = mk(OP_BR, 32'd7, 32'd7, 32'd0, 1'b0, 2'd0);
        ins.target = 32'h1C00_0040;
        issue(ins);
        issue(mk(OP_ADD, 32'd100, 32'd1, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_MOD,  32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_DIVU, 32'd10, 32'd0, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_MODU, 32'd10, 32'd0, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'd0));
        issue(mk(OP_STORE, 32'h1000, 32'h0000_00AB, 32'd3, 1'b0, 2'd0));
        issue(mk(OP_STORE, 32'h1000, 32'h0000_1234, 32'd1, 1'b0, 2'd1));
        drain();

        // Store held by MEM for three cycles: a single write on release
        force_allow = 1'b0;
        issue(mk(OP_STORE, 32'h2000, 32'hCAFE_BEEF, 32'd4, 1'b0, 2'd2));
        repeat (3) @(posedge clk);
        #1 force_allow = 1'b1;
        drain();

        // Random traffic with MEM backpressure
        bp_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue(rand_ins());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        bp_en = 1'b0;
        force_allow = 1'b1;
        drain();

        // Reset in the middle of a divide aborts it
        issue(mk(OP_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, 2'd0));
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        expq.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_valid", 32'(mem_valid), 32'd0);
        chk("abort_allow_in", 32'(ex_allow_in), 32'd1);
        chk("abort_result", mem_result, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(mk(OP_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 2'd0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
